spike_decoder: RTL and testbench

Receive-side counterpart to the Izhikevich neuron tile: the neuron turns an input current into a spike train, and this block turns a spike train back into numbers. It takes a synchronous 1-bit spike line (a neuron's spike output, or an external pin) and measures two things. The first is spike rate over a fixed tumbling window. The second is the inter-spike interval (ISI) between consecutive spikes, with a burst flag. It sits beside the neuron in the Tiny Tapeout top level; its outputs drive uo_out/uio_out for rate readback or closed-loop experiments.

---
 rtl/spike_pkg.sv | 9 +
 rtl/sat_counter.sv | 30 +++
 rtl/spike_decoder.sv | 96 +++++++++
 tb/tb_spike_decoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared spike-path constants, used by the neuron tile and the spike decoder.
package spike_pkg;

   localparam int WIN_LOG2_DEF  = 8;
   localparam int RATE_W_DEF    = 8;
   localparam int ISI_W_DEF     = 16;
   localparam int BURST_ISI_DEF = 16;

endpackage : spike_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr restarts from zero and inc still
// applies in the same cycle, so clr&inc loads 1.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_base;

   assign w_base = clr ? '0 : r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (inc && !(&w_base)) begin
         r_q <= w_base + W'(1);
      end else begin
         r_q <= w_base;
      end
   end

   assign q = r_q;

endmodule : sat_counter

// File: rtl/spike_decoder.sv
// Turns a 1-bit spike line into a windowed spike rate and an inter-spike
// interval with a burst flag.
module spike_decoder
   import spike_pkg::*;
#(
   parameter int WIN_LOG2  = WIN_LOG2_DEF,
   parameter int RATE_W    = RATE_W_DEF,
   parameter int ISI_W     = ISI_W_DEF,
   parameter int BURST_ISI = BURST_ISI_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spike,
   output logic [RATE_W-1:0] rate,
   output logic              rate_valid,
   output logic [ISI_W-1:0]  isi,
   output logic              isi_valid,
   output logic              burst
);

   // One extra bit so any BURST_ISI up to 2^ISI_W compares correctly.
   localparam logic [ISI_W:0] BURST_LIM = (ISI_W+1)'(BURST_ISI);

   logic                r_spike_q;
   logic [WIN_LOG2-1:0] r_win_cnt;
   logic                r_armed;
   logic [RATE_W-1:0]   r_rate;
   logic                r_rate_valid;
   logic [ISI_W-1:0]    r_isi;
   logic                r_isi_valid;
   logic                r_burst;

   logic                w_edge;
   logic                w_win_close;
   logic [RATE_W-1:0]   w_acc;
   logic [RATE_W-1:0]   w_acc_sum;
   logic [ISI_W-1:0]    w_isi_cnt;
   logic                w_burst;

   assign w_edge      = spike & ~r_spike_q;
   assign w_win_close = &r_win_cnt;
   // An edge in the closing cycle still belongs to the closing window.
   assign w_acc_sum   = (&w_acc) ? w_acc : w_acc + RATE_W'(w_edge);
   assign w_burst     = ({1'b0, w_isi_cnt} < BURST_LIM);

   sat_counter #(.W(RATE_W)) u_acc (
      .clk (clk),
      .rst (reset),
      .clr (w_win_close),
      .inc (w_edge & ~w_win_close),
      .q   (w_acc)
   );

   sat_counter #(.W(ISI_W)) u_isi_cnt (
      .clk (clk),
      .rst (reset),
      .clr (w_edge),
      .inc (1'b1),
      .q   (w_isi_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_spike_q    <= 1'b0;
         r_win_cnt    <= '0;
         r_armed      <= 1'b0;
         r_rate       <= '0;
         r_rate_valid <= 1'b0;
         r_isi        <= '0;
         r_isi_valid  <= 1'b0;
         r_burst      <= 1'b0;
      end else begin
         r_spike_q    <= spike;
         r_win_cnt    <= r_win_cnt + WIN_LOG2'(1);
         r_rate_valid <= w_win_close;
         if (w_win_close) begin
            r_rate <= w_acc_sum;
         end
         r_isi_valid <= w_edge & r_armed;
         if (w_edge) begin
            r_armed <= 1'b1;
            if (r_armed) begin
               r_isi   <= w_isi_cnt;
               r_burst <= w_burst;
            end
         end
      end
   end

   assign rate       = r_rate;
   assign rate_valid = r_rate_valid;
   assign isi        = r_isi;
   assign isi_valid  = r_isi_valid;
   assign burst      = r_burst;

endmodule : spike_decoder

// File: tb/tb_spike_decoder.sv
// Scoreboard bench for spike_decoder: default instance plus a narrow
// instance (RATE_W=6, ISI_W=8) for the saturation cases.
module tb_spike_decoder;

   typedef struct {
      int cyc;
      int val;
      int b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spike = 1'b0;
   logic [7:0] rate;
   logic       rate_valid;
   logic [15:0] isi;
   logic       isi_valid;
   logic       burst;

   logic       reset2 = 1'b1;
   logic       spike2 = 1'b0;
   logic [5:0] rate2;
   logic       rate_valid2;
   logic [7:0] isi2;
   logic       isi_valid2;
   logic       burst2;

   int cyc1 = 0;
   int cyc2 = 0;
   int checks = 0;
   int errors = 0;

   exp_t q_rate1[$];
   exp_t q_isi1[$];
   exp_t q_rate2[$];
   exp_t q_isi2[$];

   spike_decoder u_dut (
      .clk        (clk),
      .reset      (reset),
      .spike      (spike),
      .rate       (rate),
      .rate_valid (rate_valid),
      .isi        (isi),
      .isi_valid  (isi_valid),
      .burst      (burst)
   );

   spike_decoder #(.WIN_LOG2(8), .RATE_W(6), .ISI_W(8), .BURST_ISI(16)) u_dut2 (
      .clk        (clk),
      .reset      (reset2),
      .spike      (spike2),
      .rate       (rate2),
      .rate_valid (rate_valid2),
      .isi        (isi2),
      .isi_valid  (isi_valid2),
      .burst      (burst2)
   );

   always #5 clk = ~clk;

   // Cycle 0 is the first cycle whose closing edge sees reset low.
   always @(posedge clk) cyc1 <= reset  ? 0 : cyc1 + 1;
   always @(posedge clk) cyc2 <= reset2 ? 0 : cyc2 + 1;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input int c, input int v);
      checks++;
      errors++;
      $display("FAIL %s: unexpected pulse at cycle %0d value %0d", nm, c, v);
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rate_valid) begin
         if (q_rate1.size() == 0) unexpected("rate1", cyc1, int'(rate));
         else begin
            e = q_rate1.pop_front();
            check("rate1_cycle", cyc1, e.cyc);
            check("rate1_value", int'(rate), e.val);
         end
      end
      if (isi_valid) begin
         if (q_isi1.size() == 0) unexpected("isi1", cyc1, int'(isi));
         else begin
            e = q_isi1.pop_front();
            check("isi1_cycle", cyc1, e.cyc);
            check("isi1_value", int'(isi), e.val);
            check("isi1_burst", int'(burst), e.b);
         end
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (rate_valid2) begin
         if (q_rate2.size() == 0) unexpected("rate2", cyc2, int'(rate2));
         else begin
            e = q_rate2.pop_front();
            check("rate2_cycle", cyc2, e.cyc);
            check("rate2_value", int'(rate2), e.val);
         end
      end
      if (isi_valid2) begin
         if (q_isi2.size() == 0) unexpected("isi2", cyc2, int'(isi2));
         else begin
            e = q_isi2.pop_front();
            check("isi2_cycle", cyc2, e.cyc);
            check("isi2_value", int'(isi2), e.val);
            check("isi2_burst", int'(burst2), e.b);
         end
      end
   end

   task automatic push_r1(input int c, input int v);
      exp_t e;
      e.cyc = c; e.val = v; e.b = 0;
      q_rate1.push_back(e);
   endtask

   task automatic push_i1(input int c, input int v, input int b);
      exp_t e;
      e.cyc = c; e.val = v; e.b = b;
      q_isi1.push_back(e);
   endtask

   task automatic push_r2(input int c, input int v);
      exp_t e;
      e.cyc = c; e.val = v; e.b = 0;
      q_rate2.push_back(e);
   endtask

   task automatic push_i2(input int c, input int v, input int b);
      exp_t e;
      e.cyc = c; e.val = v; e.b = b;
      q_isi2.push_back(e);
   endtask

   task automatic goto1(input int c);
      while (cyc1 < c) @(negedge clk);
   endtask

   task automatic goto2(input int c);
      while (cyc2 < c) @(negedge clk);
   endtask

   task automatic pulse1(input int c);
      goto1(c);
      spike = 1'b1;
      goto1(c + 1);
      spike = 1'b0;
   endtask

   task automatic reset1(input logic hold);
      @(negedge clk);
      reset = 1'b1;
      spike = hold;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_rate", int'(rate), 0);
      check("rst_rate_valid", int'(rate_valid), 0);
      check("rst_isi", int'(isi), 0);
      check("rst_isi_valid", int'(isi_valid), 0);
      check("rst_burst", int'(burst), 0);
   endtask

   task automatic drain1(input string nm);
      check({nm, "_rate_q_left"}, q_rate1.size(), 0);
      check({nm, "_isi_q_left"}, q_isi1.size(), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin : stim
      // Quiet line: only zero-rate pulses at window closes.
      reset1(1'b0);
      push_r1(256, 0);
      push_r1(512, 0);
      goto1(600);
      check("quiet_isi", int'(isi), 0);
      check("quiet_burst", int'(burst), 0);
      drain1("quiet");

      // Regular 20-cycle spacing; first edge only arms.
      reset1(1'b0);
      push_i1(31, 20, 0);
      push_i1(51, 20, 0);
      push_r1(256, 3);
      pulse1(10);
      pulse1(30);
      pulse1(50);
      goto1(260);
      drain1("regular");

      // Short gap is a burst, long gap is not; values hold afterwards.
      reset1(1'b0);
      push_i1(106, 5, 1);
      push_i1(141, 35, 0);
      push_r1(256, 3);
      pulse1(100);
      pulse1(105);
      pulse1(140);
      goto1(260);
      check("hold_isi", int'(isi), 35);
      check("hold_burst", int'(burst), 0);
      drain1("burst");

      // Held level is one event; edge in the closing cycle counts there.
      reset1(1'b0);
      push_r1(256, 2);
      push_i1(256, 235, 0);
      push_r1(512, 0);
      goto1(20);
      spike = 1'b1;
      goto1(61);
      spike = 1'b0;
      pulse1(255);
      goto1(515);
      drain1("level");

      // Build acc=7 and arm, then reset mid-window with spike held high.
      reset1(1'b0);
      for (int k = 1; k < 7; k++) push_i1(11 + 2 * k, 2, 1);
      for (int k = 0; k < 7; k++) pulse1(10 + 2 * k);
      goto1(40);
      drain1("prereset");
      reset1(1'b1);
      push_i1(51, 50, 0);
      push_r1(256, 2);
      goto1(3);
      spike = 1'b0;
      pulse1(50);
      goto1(260);
      drain1("midreset");

      // Narrow instance: rate saturation and ISI saturation.
      @(negedge clk);
      reset = 1'b1;
      reset2 = 1'b1;
      spike2 = 1'b0;
      repeat (2) @(negedge clk);
      reset2 = 1'b0;
      for (int c = 2; c <= 254; c += 2) push_i2(c + 1, 2, 1);
      push_r2(256, 63);
      push_r2(512, 0);
      push_i2(601, 255, 0);
      push_r2(768, 1);
      for (int c = 0; c < 256; c++) begin
         goto2(c);
         spike2 = (c % 2 == 0);
      end
      goto2(256);
      spike2 = 1'b0;
      goto2(600);
      spike2 = 1'b1;
      goto2(601);
      spike2 = 1'b0;
      goto2(770);
      check("sat_rate_q_left", q_rate2.size(), 0);
      check("sat_isi_q_left", q_isi2.size(), 0);
      check("sat_isi_hold", int'(isi2), 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spike_decoder
